// File: rtl/mux_scan.sv
// rtl/mux_scan.sv - N-channel W-bit registered mux with direct select and time-division scan
// Scan mode walks ptr over all channels, holding each for DWELL enabled cycles.
module mux_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 2,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      en,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          chan,
  output logic                      frame
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [WIDTH-1:0] ch_data [CHANNELS];
  logic [SEL_W-1:0] ptr, ptr_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [SEL_W-1:0] dir_sel;
  logic [SEL_W-1:0] src;
  logic [WIDTH-1:0] src_data;
  logic             dwell_end;
  logic             scan_end;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign ch_data[i] = din[i*WIDTH +: WIDTH];
  end

  always_comb begin
    // Out-of-range selects (non-power-of-2 CHANNELS) land on the last channel.
    dir_sel   = (sel > PTR_LAST) ? PTR_LAST : sel;
    src       = mode ? ptr : dir_sel;
    src_data  = ch_data[src];
    dwell_end = (cnt == CNT_LAST);
    scan_end  = dwell_end && (ptr == PTR_LAST);
    ptr_next  = ptr;
    cnt_next  = cnt;
    if (!mode) begin
      ptr_next = '0;
      cnt_next = '0;
    end else if (en) begin
      if (dwell_end) begin
        cnt_next = '0;
        ptr_next = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      cnt       <= '0;
      out       <= '0;
      chan      <= '0;
      out_valid <= 1'b0;
      frame     <= 1'b0;
    end else begin
      ptr       <= ptr_next;
      cnt       <= cnt_next;
      out_valid <= en;
      frame     <= mode && en && scan_end;
      if (en) begin
        out  <= src_data;
        chan <= src;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// tb/tb_mux_scan.sv - self-checking bench for mux_scan (4ch/dwell 2 and 3ch/dwell 1 instances)
module tb_mux_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic        en = 1'b0;
  logic [31:0] din_a = 32'h4433_2211;
  logic [23:0] din_b = 24'hC3_B2A1;
  logic [1:0]  sel_a = '0;
  logic [1:0]  sel_b = '0;
  logic [7:0]  out_a, out_b;
  logic [1:0]  chan_a, chan_b;
  logic        valid_a, valid_b, frame_a, frame_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .sel(sel_a), .mode(mode), .en(en),
    .out(out_a), .out_valid(valid_a), .chan(chan_a), .frame(frame_a)
  );

  mux_scan #(.WIDTH(8), .CHANNELS(3), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .sel(sel_b), .mode(mode), .en(en),
    .out(out_b), .out_valid(valid_b), .chan(chan_b), .frame(frame_b)
  );

  // Reference model: k counts enabled scan samples since the scan (re)started.
  int         k [2];
  logic [7:0] e_out [2];
  int         e_chan [2];
  logic       e_valid [2];
  logic       e_frame [2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      k[i] = 0; e_out[i] = 8'h00; e_chan[i] = 0; e_valid[i] = 1'b0; e_frame[i] = 1'b0;
    end
  endfunction

  function automatic void model_step(int i, logic m, logic e, int s, logic [31:0] d);
    int nch, dw, c;
    nch = (i == 0) ? 4 : 3;
    dw  = (i == 0) ? 2 : 1;
    e_valid[i] = e;
    e_frame[i] = 1'b0;
    if (!m) begin
      k[i] = 0;
      if (e) begin
        c = (s < nch) ? s : nch - 1;
        e_out[i] = d[c*8 +: 8];
        e_chan[i] = c;
      end
    end else if (e) begin
      c = (k[i] / dw) % nch;
      e_out[i] = d[c*8 +: 8];
      e_chan[i] = c;
      e_frame[i] = (k[i] % (nch * dw)) == (nch * dw - 1);
      k[i] = (k[i] + 1) % (nch * dw);
    end
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    check("a_out", 32'(out_a), 32'(e_out[0]));
    check("a_chan", 32'(chan_a), 32'(e_chan[0]));
    check("a_valid", 32'(valid_a), 32'(e_valid[0]));
    check("a_frame", 32'(frame_a), 32'(e_frame[0]));
    check("b_out", 32'(out_b), 32'(e_out[1]));
    check("b_chan", 32'(chan_b), 32'(e_chan[1]));
    check("b_valid", 32'(valid_b), 32'(e_valid[1]));
    check("b_frame", 32'(frame_b), 32'(e_frame[1]));
  endtask

  // Called at a sample point (1 ns after an edge); inputs must already be driven.
  task automatic tick();
    model_step(0, mode, en, int'(sel_a), din_a);
    model_step(1, mode, en, int'(sel_b), {8'h00, din_b});
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_out_a", 32'(out_a), 32'h0);
    check("rst_valid_a", 32'(valid_a), 32'h0);
    check("rst_chan_a", 32'(chan_a), 32'h0);
    check("rst_frame_a", 32'(frame_a), 32'h0);
    check_model();
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic       m;
    logic       e;
    logic [1:0] s;
    logic [7:0] o;
    logic [1:0] c;
    logic       v;
    logic       f;
  } vec_t;

  vec_t tbl [$];

  task automatic add(logic m, logic e, logic [1:0] s, logic [7:0] o, logic [1:0] c, logic v, logic f);
    vec_t r;
    r.m = m; r.e = e; r.s = s; r.o = o; r.c = c; r.v = v; r.f = f;
    tbl.push_back(r);
  endtask

  initial begin
    // direct select, then sel change
    add(0, 1, 2, 8'h33, 2, 1, 0);
    add(0, 1, 0, 8'h11, 0, 1, 0);
    // ten-edge scan; sel is ignored
    add(1, 1, 3, 8'h11, 0, 1, 0);  add(1, 1, 3, 8'h11, 0, 1, 0);
    add(1, 1, 3, 8'h22, 1, 1, 0);  add(1, 1, 3, 8'h22, 1, 1, 0);
    add(1, 1, 3, 8'h33, 2, 1, 0);  add(1, 1, 3, 8'h33, 2, 1, 0);
    add(1, 1, 3, 8'h44, 3, 1, 0);  add(1, 1, 3, 8'h44, 3, 1, 1);
    add(1, 1, 3, 8'h11, 0, 1, 0);  add(1, 1, 3, 8'h11, 0, 1, 0);
    // restart scan, enable gap after first 0x22
    add(0, 0, 0, 8'h11, 0, 0, 0);
    add(1, 1, 0, 8'h11, 0, 1, 0);  add(1, 1, 0, 8'h11, 0, 1, 0);
    add(1, 1, 0, 8'h22, 1, 1, 0);
    add(1, 0, 0, 8'h22, 1, 0, 0);  add(1, 0, 0, 8'h22, 1, 0, 0);  add(1, 0, 0, 8'h22, 1, 0, 0);
    add(1, 1, 0, 8'h22, 1, 1, 0);  add(1, 1, 0, 8'h33, 2, 1, 0);
    // mid-scan switch to direct, then back to scan
    add(0, 1, 1, 8'h22, 1, 1, 0);
    add(1, 1, 0, 8'h11, 0, 1, 0);

    model_reset();
    #2;
    check_model();
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      mode = tbl[i].m; en = tbl[i].e; sel_a = tbl[i].s;
      tick();
      check($sformatf("tbl%0d_out", i), 32'(out_a), 32'(tbl[i].o));
      check($sformatf("tbl%0d_chan", i), 32'(chan_a), 32'(tbl[i].c));
      check($sformatf("tbl%0d_valid", i), 32'(valid_a), 32'(tbl[i].v));
      check($sformatf("tbl%0d_frame", i), 32'(frame_a), 32'(tbl[i].f));
    end

    // asynchronous reset mid-scan, then fresh start
    mode = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    async_reset();
    tick();
    check("post_rst_out", 32'(out_a), 32'h11);
    check("post_rst_chan", 32'(chan_a), 32'h0);

    // three channels, dwell 1: out-of-range direct select then scan wrap
    mode = 1'b0; en = 1'b1; sel_b = 2'd3;
    tick();
    check("b_sel3_out", 32'(out_b), 32'hC3);
    check("b_sel3_chan", 32'(chan_b), 32'h2);
    mode = 1'b1;
    tick(); check("b_scan0", 32'(out_b), 32'hA1); check("b_frame0", 32'(frame_b), 32'h0);
    tick(); check("b_scan1", 32'(out_b), 32'hB2); check("b_frame1", 32'(frame_b), 32'h0);
    tick(); check("b_scan2", 32'(out_b), 32'hC3); check("b_frame2", 32'(frame_b), 32'h1);
    tick(); check("b_scan3", 32'(out_b), 32'hA1); check("b_frame3", 32'(frame_b), 32'h0);

    // randomized run against the model, din changing every cycle
    for (int n = 0; n < 400; n++) begin
      mode  = ($urandom_range(0, 9) < 8);
      en    = ($urandom_range(0, 3) != 0);
      sel_a = 2'($urandom);
      sel_b = 2'($urandom);
      din_a = $urandom;
      din_b = 24'($urandom);
      if ($urandom_range(0, 79) == 0) async_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
Parametrised N-channel, W-bit multiplexer with a registered output. It is the successor to the fixed 4-to-1 single-bit mux. It has two modes:
- Direct: select comes from a port.
- Scan: an internal pointer cycles through all channels, holding each one for a fixed number of enabled cycles (time-division readout).

It sits between parallel data sources and a single serial or shared consumer, and marks valid samples and frame boundaries.

Parameters:
- WIDTH, 8, data width per channel (>=1).
- CHANNELS, 4, number of input channels (>=2; need not be a power of 2).
- DWELL, 2, enabled cycles spent on each channel in scan mode (>=1).
- SEL_W, $clog2(CHANNELS), select/pointer width. Derived; never overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  CHANNELS*WIDTH  flattened inputs; channel i = din[i*WIDTH +: WIDTH].
- sel  in  SEL_W  channel select, used in direct mode only.
- mode  in  1  0 = direct, 1 = scan.
- en  in  1  advance/sample enable.
- out  out  WIDTH  registered selected data.
- out_valid  out  1  out was updated on the last edge.
- chan  out  SEL_W  channel index currently presented on out.
- frame  out  1  one-cycle pulse marking the last sample of a full scan.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state (asserted at any time, including mid-scan):
  - out=0, out_valid=0, chan=0, frame=0.
  - Internal ptr=0, cnt=0.
  - Effect is immediate, not clock-gated.
  - First sampling edge after release behaves as a fresh start.
- Latency: 1 clock. Every output is a register; there is no combinational path from inputs to outputs.
- Internal state:
  - ptr (SEL_W bits): scan channel pointer.
  - cnt (range 0..DWELL-1): dwell counter.
- Direct mode (mode=0), each edge:
  - en=1: out<=din[s], chan<=s, out_valid<=1, frame<=0.
  - s = sel if sel<CHANNELS, otherwise s = CHANNELS-1 (out-of-range select maps to the last channel).
  - ptr and cnt are forced to 0 whenever mode=0, regardless of en.
  - en=0: out and chan hold; out_valid<=0; frame<=0.
- Scan mode (mode=1), edge with en=1:
  - out<=din[ptr], chan<=ptr, out_valid<=1.
  - If cnt==DWELL-1: cnt<=0 and ptr<=(ptr==CHANNELS-1) ? 0 : ptr+1.
  - Otherwise: cnt<=cnt+1, ptr holds.
  - frame<=1 only when ptr==CHANNELS-1 and cnt==DWELL-1 before the edge; 0 otherwise.
  - sel is ignored.
- Scan mode, edge with en=0:
  - ptr, cnt, out and chan hold.
  - out_valid<=0, frame<=0.
  - Scan resumes at the exact position it paused.
- Mode transitions:
  - 1->0 mid-scan: the next edge is a direct-mode sample; the scan position is discarded.
  - 0->1: the first scan sample is always channel 0, dwell position 0.
- Boundary cases:
  - DWELL=1: cnt is always 0; ptr advances every enabled edge.
  - Non-power-of-2 CHANNELS: ptr never takes values >= CHANNELS; wrap occurs at CHANNELS-1.
  - din changing mid-dwell: each edge samples the current din (no hold of the first sample).

Test Plan:
All scenarios use WIDTH=8, CHANNELS=4, DWELL=2 and din={8'h44,8'h33,8'h22,8'h11} unless noted.
1. Reset: run a scan, then pull rst_n low between edges -> out=0x00, out_valid=0, chan=0, frame=0 immediately; after release with mode=1, en=1, the first sample is 0x11, chan=0.
2. Direct: mode=0, en=1, sel=2 -> next edge out=0x33, chan=2, out_valid=1, frame=0. Change sel to 0 -> following edge out=0x11.
3. Scan sequence: mode=1, en=1 for 10 edges -> out=11,11,22,22,33,33,44,44,11,11; chan=0,0,1,1,2,2,3,3,0,0; frame high only on the second 0x44 sample.
4. Enable gap: scan, drop en after the first 0x22 sample for 3 cycles -> out holds 0x22 with out_valid=0; on re-enable the next sample is 0x22 (second dwell), then 0x33.
5. Mode switch: mid-scan at channel 2 set mode=0 with sel=1 for 1 edge (out=0x22), then mode=1 -> scan restarts at 0x11, chan=0.
6. Odd channel count: CHANNELS=3, DWELL=1, din={8'hC3,8'hB2,8'hA1}:
   - Direct with sel=3 -> out=0xC3, chan=2.
   - Scan -> A1,B2,C3,A1; frame on C3.
